// File: rtl/result_to_ascii_formatter.sv
// Converts a WIDTH-bit result into a NUL-terminated ASCII decimal string.
// Uses bit-serial divide-by-10. Define SIGNED_FORMAT_EN to treat value_i as two's complement.
module result_to_ascii_formatter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned MAXSTR = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [WIDTH-1:0]             value_i,
  output logic [8*MAXSTR-1:0]          ascii_out_o,
  output logic [$clog2(MAXSTR+1)-1:0]  length_o,
  output logic                         ready_o
);

  // Decimal digits of 2^WIDTH-1: floor(WIDTH*log10(2)) + 1.
  localparam int unsigned MaxDigits = (WIDTH * 30103) / 100000 + 1;
  localparam int unsigned LenW      = $clog2(MAXSTR + 1);
  localparam int unsigned CntW      = $clog2(MaxDigits + 1);
  localparam int unsigned BitW      = $clog2(WIDTH);

  if (MAXSTR < MaxDigits + 2) begin : g_bad_maxstr
    $error("MAXSTR too small for WIDTH: need sign, digits and NUL");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("WIDTH must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StDiv,
    StPush,
    StSign,
    StEmit,
    StTerm
  } state_e;

  state_e                   state_q, state_d;
  logic [WIDTH-1:0]         div_q, div_d;
  logic [3:0]               rem_q, rem_d;
  logic [BitW-1:0]          bit_q, bit_d;
  logic [8*MaxDigits-1:0]   stack_q, stack_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [LenW-1:0]          pos_q, pos_d;
  logic                     neg_q, neg_d;
  logic [8*MAXSTR-1:0]      ascii_q, ascii_d;
  logic [LenW-1:0]          len_q, len_d;
  logic                     ready_q, ready_d;

  logic                     in_neg;
  logic [WIDTH-1:0]         in_mag;
  logic [4:0]               rem_shift;
  logic                     rem_ge;
  logic [3:0]               rem_sub;
  logic [3:0]               rem_next;
  logic [CntW-1:0]          top_idx;

`ifdef SIGNED_FORMAT_EN
  assign in_neg = value_i[WIDTH-1];
  assign in_mag = in_neg ? (~value_i + 1'b1) : value_i;
`else
  assign in_neg = 1'b0;
  assign in_mag = value_i;
`endif

  // Restoring step: shift in the next dividend bit, subtract 10 when it fits.
  // Subtraction is done mod 16, exact whenever rem_ge holds.
  assign rem_shift = {rem_q, div_q[WIDTH-1]};
  assign rem_ge    = (rem_shift >= 5'd10);
  assign rem_sub   = rem_shift[3:0] - 4'd10;
  assign rem_next  = rem_ge ? rem_sub : rem_shift[3:0];
  assign top_idx   = cnt_q - CntW'(1);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    rem_d   = rem_q;
    bit_d   = bit_q;
    stack_d = stack_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    neg_d   = neg_q;
    ascii_d = ascii_q;
    len_d   = len_q;
    ready_d = ready_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          neg_d   = in_neg;
          div_d   = in_mag;
          rem_d   = '0;
          bit_d   = '0;
          cnt_d   = '0;
          ascii_d = '0;
          ready_d = 1'b0;
          state_d = StDiv;
        end
      end
      StDiv: begin
        // Quotient bits shift into div_q as the dividend bits shift out.
        div_d = {div_q[WIDTH-2:0], rem_ge};
        rem_d = rem_next;
        bit_d = bit_q + BitW'(1);
        if (bit_q == BitW'(WIDTH - 1)) begin
          state_d = StPush;
        end
      end
      StPush: begin
        stack_d[8*cnt_q +: 8] = {4'h3, rem_q};
        cnt_d   = cnt_q + CntW'(1);
        rem_d   = '0;
        bit_d   = '0;
        state_d = (div_q == '0) ? StSign : StDiv;
      end
      StSign: begin
        if (neg_q) begin
          ascii_d[7:0] = 8'h2D;
          pos_d        = LenW'(1);
        end else begin
          pos_d = '0;
        end
        state_d = StEmit;
      end
      StEmit: begin
        ascii_d[8*pos_q +: 8] = stack_q[8*top_idx +: 8];
        pos_d = pos_q + LenW'(1);
        cnt_d = top_idx;
        if (cnt_q == CntW'(1)) begin
          state_d = StTerm;
        end
      end
      StTerm: begin
        ascii_d[8*pos_q +: 8] = 8'h00;
        len_d   = pos_q;
        ready_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      div_q   <= '0;
      rem_q   <= '0;
      bit_q   <= '0;
      stack_q <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      neg_q   <= 1'b0;
      ascii_q <= '0;
      len_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      bit_q   <= bit_d;
      stack_q <= stack_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      ascii_q <= ascii_d;
      len_q   <= len_d;
      ready_q <= ready_d;
    end
  end

  assign ascii_out_o = ascii_q;
  assign length_o    = len_q;
  assign ready_o     = ready_q;

endmodule
